// File: rtl/signal_sync_filter_multi.sv
// Multi-channel level synchroniser into clkB with per-channel stability filter.
// Define SIGNAL_SYNC_EDGE_EN to add registered-source Rise_clkB/Fall_clkB edge pulses.
module signal_sync_filter_multi #(
    parameter int unsigned      WIDTH      = 1,
    parameter int unsigned      STAGES     = 2,
    parameter int unsigned      FILTER_CNT = 0,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clkB,
    input  logic             rst,
    input  logic [WIDTH-1:0] SignalIn_clkA,
`ifdef SIGNAL_SYNC_EDGE_EN
    output logic [WIDTH-1:0] SignalOut_clkB,
    output logic [WIDTH-1:0] Rise_clkB,
    output logic [WIDTH-1:0] Fall_clkB
`else
    output logic [WIDTH-1:0] SignalOut_clkB
`endif
);

    if (STAGES < 2) begin : gen_bad_stages
        $error("signal_sync_filter_multi: STAGES must be >= 2");
    end
    if (WIDTH < 1) begin : gen_bad_width
        $error("signal_sync_filter_multi: WIDTH must be >= 1");
    end

    // Pure flop chain: nothing may sit between stages or metastability settling time is lost.
    logic [WIDTH-1:0] syncQ [STAGES];
    logic [WIDTH-1:0] syncS;

    always_ff @(posedge clkB or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                syncQ[k] <= RESET_VAL;
            end
        end else begin
            syncQ[0] <= SignalIn_clkA;
            for (int k = 1; k < STAGES; k++) begin
                syncQ[k] <= syncQ[k-1];
            end
        end
    end

    assign syncS = syncQ[STAGES-1];

    if (FILTER_CNT == 0) begin : gen_bypass
        assign SignalOut_clkB = syncS;
    end else begin : gen_filter
        localparam int unsigned     CntW   = $clog2(FILTER_CNT + 1);
        localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CNT - 1);

        logic [CntW-1:0]  cntQ [WIDTH];
        logic [WIDTH-1:0] outQ;

        // A channel's count runs only while its synchronised level disagrees with the output;
        // any return to the old level throws the partial count away.
        always_ff @(posedge clkB or posedge rst) begin
            if (rst) begin
                outQ <= RESET_VAL;
                for (int i = 0; i < WIDTH; i++) begin
                    cntQ[i] <= '0;
                end
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (syncS[i] == outQ[i]) begin
                        cntQ[i] <= '0;
                    end else if (cntQ[i] == CntMax) begin
                        outQ[i] <= syncS[i];
                        cntQ[i] <= '0;
                    end else begin
                        cntQ[i] <= cntQ[i] + CntW'(1);
                    end
                end
            end
        end

        assign SignalOut_clkB = outQ;
    end

`ifdef SIGNAL_SYNC_EDGE_EN
    // out_d shares the output's reset value, so reset release never looks like an edge.
    logic [WIDTH-1:0] out_d;

    always_ff @(posedge clkB or posedge rst) begin
        if (rst) begin
            out_d <= RESET_VAL;
        end else begin
            out_d <= SignalOut_clkB;
        end
    end

    assign Rise_clkB = SignalOut_clkB & ~out_d;
    assign Fall_clkB = ~SignalOut_clkB & out_d;
`endif

endmodule

// File: tb/tb_signal_sync_filter_multi.sv
// Self-checking bench for signal_sync_filter_multi: vector table, corner sequences, random vs model.
`timescale 1ns/1ps
module tb_signal_sync_filter_multi;

    logic clkB = 1'b0;
    always #5 clkB = ~clkB;

    logic       rstA, rstB, rstC;
    logic [3:0] inA, inB, inC;
    logic [3:0] outA, outB, outC;
`ifdef SIGNAL_SYNC_EDGE_EN
    logic [3:0] riseA, fallA, riseB, fallB, riseC, fallC;
`endif

    // A: filtered, B: unfiltered 3-stage, C: filtered with non-zero reset value
    signal_sync_filter_multi #(.WIDTH(4), .STAGES(2), .FILTER_CNT(3), .RESET_VAL(4'h0)) dutA (
        .clkB(clkB), .rst(rstA), .SignalIn_clkA(inA), .SignalOut_clkB(outA)
`ifdef SIGNAL_SYNC_EDGE_EN
        , .Rise_clkB(riseA), .Fall_clkB(fallA)
`endif
    );

    signal_sync_filter_multi #(.WIDTH(4), .STAGES(3), .FILTER_CNT(0), .RESET_VAL(4'h0)) dutB (
        .clkB(clkB), .rst(rstB), .SignalIn_clkA(inB), .SignalOut_clkB(outB)
`ifdef SIGNAL_SYNC_EDGE_EN
        , .Rise_clkB(riseB), .Fall_clkB(fallB)
`endif
    );

    signal_sync_filter_multi #(.WIDTH(4), .STAGES(2), .FILTER_CNT(3), .RESET_VAL(4'hA)) dutC (
        .clkB(clkB), .rst(rstC), .SignalIn_clkA(inC), .SignalOut_clkB(outC)
`ifdef SIGNAL_SYNC_EDGE_EN
        , .Rise_clkB(riseC), .Fall_clkB(fallC)
`endif
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    endtask

    typedef struct {
        logic [3:0] in;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t tbl[$];

    task automatic addRun(input int n, input logic [3:0] in, input logic [3:0] out,
                          input logic [3:0] rise, input logic [3:0] fall);
        vec_t v;
        v.in = in; v.out = out; v.rise = rise; v.fall = fall;
        repeat (n) tbl.push_back(v);
    endtask

    // Synchronised level after edge k (history h[k] = input held before edge k).
    function automatic logic [3:0] sAt(input logic [3:0] h[$], input int k, input int S,
                                       input logic [3:0] R);
        return (k >= S) ? h[k-S+1] : R;
    endfunction

    // Output after edge e: a level is taken once it has been seen unanimously over the last F
    // edges since reset; otherwise the previous output holds.
    function automatic logic [3:0] modelOut(input logic [3:0] h[$], input int e, input int S,
                                            input int F, input logic [3:0] R,
                                            input logic [3:0] prev);
        logic [3:0] first, same;
        if (F == 0) return sAt(h, e, S, R);
        if (e < F) return prev;
        first = sAt(h, e - F, S, R);
        same  = 4'hF;
        for (int k = e - F + 1; k < e; k++) same &= ~(sAt(h, k, S, R) ^ first);
        return (same & first) | (~same & prev);
    endfunction

    task automatic runRandom(input int which, input int S, input int F, input logic [3:0] R,
                             input int n);
        logic [3:0] h[$];
        logic [3:0] cur, prev, exp, act;
        string      tag;
        tag = (which == 0) ? "rndA" : "rndB";
        cur = R;
        if (which == 0) begin inA = cur; rstA = 1'b1; end
        else begin inB = cur; rstB = 1'b1; end
        repeat (2) @(negedge clkB);
        if (which == 0) rstA = 1'b0; else rstB = 1'b0;
        h.push_back(R);
        prev = R;
        for (int e = 1; e <= n; e++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) cur[b] = ~cur[b];
            if (which == 0) inA = cur; else inB = cur;
            @(posedge clkB);
            h.push_back(cur);
            exp = modelOut(h, e, S, F, R, prev);
            @(negedge clkB);
            act = (which == 0) ? outA : outB;
            check({tag, ".out"}, act, exp);
`ifdef SIGNAL_SYNC_EDGE_EN
            check({tag, ".rise"}, (which == 0) ? riseA : riseB, exp & ~prev);
            check({tag, ".fall"}, (which == 0) ? fallA : fallB, ~exp & prev);
`endif
            prev = exp;
        end
    endtask

    initial begin
        logic [3:0] expB [4];
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        inA = 4'h0; inB = 4'h0; inC = 4'hA;

        // Step, glitch rejection, acceptance, and simultaneous-channel vectors for dutA
        addRun(4, 4'h5, 4'h0, 4'h0, 4'h0);
        addRun(1, 4'h5, 4'h5, 4'h5, 4'h0);
        addRun(3, 4'h5, 4'h5, 4'h0, 4'h0);
        addRun(2, 4'h7, 4'h5, 4'h0, 4'h0);
        addRun(3, 4'h5, 4'h5, 4'h0, 4'h0);
        addRun(3, 4'h7, 4'h5, 4'h0, 4'h0);
        addRun(1, 4'h5, 4'h5, 4'h0, 4'h0);
        addRun(1, 4'h5, 4'h7, 4'h2, 4'h0);
        addRun(2, 4'h5, 4'h7, 4'h0, 4'h0);
        addRun(1, 4'h5, 4'h5, 4'h0, 4'h2);
        addRun(1, 4'h5, 4'h5, 4'h0, 4'h0);
        addRun(4, 4'hD, 4'h5, 4'h0, 4'h0);
        addRun(1, 4'hD, 4'hD, 4'h8, 4'h0);
        addRun(1, 4'hD, 4'hD, 4'h0, 4'h0);
        addRun(2, 4'h7, 4'hD, 4'h0, 4'h0);
        addRun(2, 4'h5, 4'hD, 4'h0, 4'h0);
        addRun(1, 4'h5, 4'h5, 4'h0, 4'h8);
        addRun(1, 4'h5, 4'h5, 4'h0, 4'h0);

        repeat (2) @(negedge clkB);
        check("rst.outA", outA, 4'h0);
        check("rst.outC", outC, 4'hA);
        rstA = 1'b0;
        foreach (tbl[i]) begin
            inA = tbl[i].in;
            @(negedge clkB);
            check($sformatf("vec%0d.out", i + 1), outA, tbl[i].out);
`ifdef SIGNAL_SYNC_EDGE_EN
            check($sformatf("vec%0d.rise", i + 1), riseA, tbl[i].rise);
            check($sformatf("vec%0d.fall", i + 1), fallA, tbl[i].fall);
`endif
        end

        // Reset in the middle of a filter count, then asynchronous reset with output set
        rstA = 1'b1; inA = 4'h0;
        @(negedge clkB);
        rstA = 1'b0; inA = 4'hF;
        repeat (4) @(negedge clkB);
        check("midf.pre", outA, 4'h0);
        rstA = 1'b1;
        #1;
        check("midf.rst", outA, 4'h0);
        @(negedge clkB);
        rstA = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clkB);
            check($sformatf("midf.post%0d", k), outA, (k == 5) ? 4'hF : 4'h0);
`ifdef SIGNAL_SYNC_EDGE_EN
            check($sformatf("midf.rise%0d", k), riseA, (k == 5) ? 4'hF : 4'h0);
`endif
        end
        rstA = 1'b1;
        #1;
        check("async.out", outA, 4'h0);
`ifdef SIGNAL_SYNC_EDGE_EN
        check("async.rise", riseA, 4'h0);
        check("async.fall", fallA, 4'h0);
`endif
        @(negedge clkB);
        rstA = 1'b0;

        // Unfiltered 3-stage path: step latency and a single-cycle pulse passing through
        rstB = 1'b0; inB = 4'h9;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clkB);
            check($sformatf("byp.step%0d", k), outB, (k == 3) ? 4'h9 : 4'h0);
        end
        inB = 4'h8;
        @(negedge clkB);
        inB = 4'h9;
        expB[0] = 4'h9; expB[1] = 4'h9; expB[2] = 4'h8; expB[3] = 4'h9;
        check("byp.pulse4", outB, expB[0]);
        for (int k = 1; k < 4; k++) begin
            @(negedge clkB);
            check($sformatf("byp.pulse%0d", k + 4), outB, expB[k]);
        end

        // Non-zero reset value held across release
        rstC = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clkB);
            check("rv.out", outC, 4'hA);
`ifdef SIGNAL_SYNC_EDGE_EN
            check("rv.rise", riseC, 4'h0);
            check("rv.fall", fallC, 4'h0);
`endif
        end

        runRandom(0, 2, 3, 4'h0, 300);
        runRandom(1, 3, 0, 4'h0, 300);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/signal_sync_filter_multi.md
Name: signal_sync_filter_multi

Overview:
- Parametrised successor to the team's single-bit two-flop synchroniser.
- Brings WIDTH independent asynchronous level signals into the clkB domain through an N-stage synchroniser chain.
- Adds a per-channel stability (glitch/debounce) filter, a defined reset value, and optional edge-pulse outputs.
- Used wherever buttons, status lines or slow control levels from foreign clock domains enter clkB logic.

Parameters:
- WIDTH, 1, number of independent channels; must be >= 1.
- STAGES, 2, synchroniser flops per channel; must be >= 2; elaboration error otherwise.
- FILTER_CNT, 0, consecutive clkB cycles a new synchronised level must persist before it is accepted; 0 = filter bypassed.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into every sync flop and output on reset.

Ports:
- clkB  input  1  destination-domain clock; all flops on posedge.
- rst  input  1  asynchronous, active-high reset.
- SignalIn_clkA  input  WIDTH  asynchronous level inputs; no timing relation to clkB.
- SignalOut_clkB  output  WIDTH  synchronised, filtered levels.
- Rise_clkB  output  WIDTH  per-channel one-cycle rising-edge pulse; present only with SIGNAL_SYNC_EDGE_EN.
- Fall_clkB  output  WIDTH  per-channel one-cycle falling-edge pulse; present only with SIGNAL_SYNC_EDGE_EN.

Behaviour:
- Reset is asynchronous and active-high.
  - While rst=1: all sync flops, SignalOut_clkB, and the internal out_d register = RESET_VAL.
  - While rst=1: all counters = 0; Rise_clkB/Fall_clkB = 0.
  - Reset asserted mid-filter discards the pending count; no pulse is produced.
- Sync chain per channel:
  - sync[0] <= SignalIn_clkA[i].
  - sync[k] <= sync[k-1].
  - s[i] = sync[STAGES-1]. No logic is allowed between stages.
- FILTER_CNT=0: SignalOut_clkB = s directly, with no added flop.
  - Latency from a stable input change to output: STAGES edges.
- FILTER_CNT>0: per-channel counter, width $clog2(FILTER_CNT+1), and output register out. Each edge:
  - s==out: cnt <= 0.
  - s!=out and cnt==FILTER_CNT-1: out <= s, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - Latency from a stable input change: exactly STAGES+FILTER_CNT edges.
  - Pulses at s shorter than FILTER_CNT cycles are rejected entirely; a return to the old level clears the count.
- Channels are fully independent.
  - Simultaneous changes on several channels are each filtered separately.
  - No cross-channel coherency is guaranteed; multi-bit buses must not be passed through this block.
- No combinational path from SignalIn_clkA to any output.
- Counter never exceeds FILTER_CNT-1 and never wraps.

Optional Feature:
- Macro SIGNAL_SYNC_EDGE_EN.
- Defined:
  - out_d <= SignalOut_clkB each edge.
  - Rise_clkB = SignalOut_clkB & ~out_d; Fall_clkB = ~SignalOut_clkB & out_d, both driven from flops.
  - Each pulse is high exactly one cycle: the first cycle SignalOut_clkB shows the new value.
  - out_d resets to RESET_VAL, so no spurious pulse occurs at reset release.
- Undefined: Rise_clkB, Fall_clkB and out_d do not exist; the port list ends at SignalOut_clkB.

Test Plan:
- WIDTH=4, STAGES=2, FILTER_CNT=3, RESET_VAL=0: input 4'h0 -> 4'h5 just before edge 1 -> SignalOut_clkB=4'h5 after edge 5, not before; Rise_clkB=4'h5 for one cycle; Fall_clkB=0.
- Same configuration, bit0 driven high for 2 clkB cycles then low -> SignalOut_clkB stays 4'h0, no pulses; held for 3 cycles -> accepted at edge STAGES+3.
- Same configuration, input 4'hF steady, rst pulsed mid-filter (after 2 of 3 count cycles):
  - Outputs go to 0 immediately without a clock edge; pulses 0.
  - After release, output 4'hF at edge 5 post-release.
- STAGES=3, FILTER_CNT=0: step 4'h0 -> 4'h9 -> output 4'h9 after edge 3; 1-cycle input pulse that reaches s passes through unfiltered.
- RESET_VAL=4'hA, input held 4'hA across reset release -> output stays 4'hA; Rise_clkB/Fall_clkB stay 0 for 20 cycles.
- Simultaneous: bit3 1->0 stable while bit1 glitches 2 cycles -> Fall_clkB[3] pulses once at edge 5; bit1 output and pulses unchanged.
